// File: rtl/spike_serializer.sv
// Latches a spike vector on each step tick and serialises the set indices,
// highest first, over a valid/ready handshake; reports count, done and overrun.
module spike_serializer #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NUM_NEURONS-1:0] spike_vec_i,
  output logic                   out_valid_o,
  output logic [IDX_W-1:0]       out_idx_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       spike_cnt_o,
  output logic                   overrun_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] pending_clr;
  logic [CNT_W-1:0]       cnt;
  logic                   ovr;
  logic                   fire;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    out_idx_o = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      if (pending[i]) out_idx_o = IDX_W'(i);
  end

  assign out_valid_o = (state == SEND) && (|pending);
  assign fire        = out_valid_o && out_ready_i;
  assign pending_clr = pending & ~(NUM_NEURONS'(1) << out_idx_o);
  assign busy_o      = (state == SEND);
  assign done_o      = (state == DONE);
  assign spike_cnt_o = cnt;
  assign overrun_o   = ovr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pending <= '0;
      cnt     <= '0;
      ovr     <= 1'b0;
    end else begin
      ovr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            pending <= spike_vec_i;
            cnt     <= '0;
            state   <= (|spike_vec_i) ? SEND : DONE;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          // A tick while still sending is dropped and flagged.
          if (start_i) ovr <= 1'b1;
          if (fire) begin
            pending <= pending_clr;
            cnt     <= cnt + CNT_W'(1);
            if (pending_clr == '0) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
